icache_refill: RTL and testbench

Line-refill controller directly downstream of the instruction cache. It accepts a miss request carrying a 32-bit fetch address. It streams the 16 bytes of the enclosing line from the byte-wide main-memory read port and returns the assembled 128-bit line to the cache with a one-cycle done pulse. It owns the fetch-side RAM port; the memory arbiter can freeze it with a stall input.

---
 rtl/icache_refill_pkg.sv | 20 ++
 rtl/icache_refill.sv | 125 ++++++++++++
 tb/tb_icache_refill.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_pkg.sv
// Shared types and line-geometry constants for the instruction-cache refill path.
package icache_refill_pkg;

  // Line geometry: 16 bytes per line, 128-bit line, 4-bit byte offset.
  localparam int unsigned LineLn   = 128;
  localparam int unsigned LineOffW = 4;
  localparam int unsigned AddrW    = 32;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDone
  } state_e;

  // Byte address of the first byte of the line containing addr.
  function automatic logic [AddrW-1:0] line_base(input logic [AddrW-1:0] addr);
    return {addr[AddrW-1:LineOffW], {LineOffW{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line refill controller: streams the 16 bytes of a missed line
// from a byte-wide RAM port and returns the assembled 128-bit line with a done pulse.
// Optional build macro ICACHE_REFILL_DEDUP_EN suppresses the cache's stale re-request
// for the line that has just been delivered.
module icache_refill
  import icache_refill_pkg::*;
#(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              done,
  output logic [LineLn-1:0] line,
  output logic              busy,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_din,
  input  logic              mem_stall
);

  localparam int unsigned BaseW = ADDR_W - LineOffW;

  state_e           state_q;
  logic [BaseW-1:0] base_q;
  logic [4:0]       ic_q;     // bytes issued so far; also index of byte on the bus
  logic [4:0]       cc_q;     // bytes captured so far
  logic             en_d_q;   // a byte was issued last cycle, its data arrives now

  logic [4:0]       ic_next;
  logic             issue_next;
  logic             dup_hit;
  logic             start;

`ifdef ICACHE_REFILL_DEDUP_EN
  logic [BaseW-1:0] last_base_q;
  logic [1:0]       dedup_cnt_q;  // edges left in the suppression window
`endif

  // Issue-side next state and request qualification.
  always_comb begin
    ic_next    = ic_q + {4'd0, ram_en};
    issue_next = !ic_next[4] && !mem_stall;
`ifdef ICACHE_REFILL_DEDUP_EN
    dup_hit    = (dedup_cnt_q != 2'd0) && (req_addr[ADDR_W-1:LineOffW] == last_base_q);
`else
    dup_hit    = 1'b0;
`endif
    start      = req && !dup_hit;
  end

  // Refill FSM with registered outputs; flush overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      base_q   <= '0;
      ic_q     <= '0;
      cc_q     <= '0;
      en_d_q   <= 1'b0;
      done     <= 1'b0;
      line     <= '0;
      busy     <= 1'b0;
      ram_en   <= 1'b0;
      ram_addr <= '0;
`ifdef ICACHE_REFILL_DEDUP_EN
      last_base_q <= '0;
      dedup_cnt_q <= '0;
`endif
    end else begin
      done   <= 1'b0;
      en_d_q <= ram_en;
`ifdef ICACHE_REFILL_DEDUP_EN
      if (dedup_cnt_q != 2'd0) dedup_cnt_q <= dedup_cnt_q - 2'd1;
`endif
      if (flush) begin
        // Abort: drop any in-flight byte and return to idle without done.
        state_q <= StIdle;
        busy    <= 1'b0;
        ram_en  <= 1'b0;
        en_d_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            state_q <= StIdle;
            busy    <= 1'b0;
            ram_en  <= 1'b0;
            if (start) begin
              state_q  <= StFill;
              base_q   <= req_addr[ADDR_W-1:LineOffW];
              ic_q     <= '0;
              cc_q     <= '0;
              busy     <= 1'b1;
              ram_en   <= !mem_stall;
              ram_addr <= line_base(req_addr);
            end
          end
          StFill: begin
            ic_q   <= ic_next;
            ram_en <= issue_next;
            if (issue_next) ram_addr <= {base_q, ic_next[3:0]};
            if (en_d_q) begin
              line[{cc_q[3:0], 3'b000} +: 8] <= ram_din;
              cc_q <= cc_q + 5'd1;
              if (cc_q == 5'(LINE_BYTES - 1)) begin
                state_q <= StDone;
                done    <= 1'b1;
                busy    <= 1'b0;
                ram_en  <= 1'b0;
`ifdef ICACHE_REFILL_DEDUP_EN
                last_base_q <= base_q;
                dedup_cnt_q <= 2'd2;
`endif
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: directed steps drive requests, a scoreboard
// holds the expected RAM address stream and expected (line, done-cycle) pairs.
module tb_icache_refill;

  logic         clk;
  logic         rst;
  logic         req;
  logic [31:0]  req_addr;
  logic         flush;
  logic         done;
  logic [127:0] line;
  logic         busy;
  logic         ram_en;
  logic [31:0]  ram_addr;
  logic [7:0]   ram_din;
  logic         mem_stall;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic [31:0] addr_q[$];
  exp_t        line_q[$];

  icache_refill dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .flush     (flush),
    .done      (done),
    .line      (line),
    .busy      (busy),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .mem_stall (mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory content: byte at a = 0x10 + a[3:0] + (a[15:8] ^ 0x12).
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = {4'h0, a[3:0]};
    hi = a[15:8] ^ 8'h12;
    return 8'h10 + lo + hi;
  endfunction

  function automatic logic [127:0] exp_line(input logic [31:0] base);
    logic [127:0] l;
    l = '0;
    for (int k = 0; k < 16; k++) l[k*8 +: 8] = ram_byte(base + 32'(k));
    return l;
  endfunction

  // RAM model: one-cycle read latency.
  always @(posedge clk) if (ram_en) ram_din <= ram_byte(ram_addr);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_en) begin
        checks++;
        assert (addr_q.size() != 0) else begin
          errors++;
          $error("FAIL addr_unexpected got %0h exp none", ram_addr);
        end
        if (addr_q.size() != 0) check("ram_addr", 128'(ram_addr), 128'(addr_q.pop_front()));
      end
      if (done) begin
        checks++;
        assert (line_q.size() != 0) else begin
          errors++;
          $error("FAIL done_unexpected got 1 exp 0 at cycle %0d", cyc);
        end
        if (line_q.size() != 0) begin
          exp_t e;
          e = line_q.pop_front();
          check("line", line, e.data);
          check("done_cycle", 128'(cyc), 128'(e.cyc));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expect a full fill whose request is sampled at edge e0, with extra stall cycles.
  task automatic push_fill(input logic [31:0] a, input int e0, input int extra);
    logic [31:0] base;
    exp_t e;
    base = {a[31:4], 4'h0};
    for (int k = 0; k < 16; k++) addr_q.push_back(base + 32'(k));
    e.data = exp_line(base);
    e.cyc  = e0 + 17 + extra;
    line_q.push_back(e);
  endtask

  task automatic drained(input string tag);
    check({tag, "_addr_q"}, 128'(addr_q.size()), 128'd0);
    check({tag, "_line_q"}, 128'(line_q.size()), 128'd0);
  endtask

  initial begin
    int e0;
    rst = 1'b0; req = 1'b0; req_addr = '0; flush = 1'b0; mem_stall = 1'b0;
    #2;
    check("rst_done", 128'(done), 128'd0);
    check("rst_line", line, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_ram_en", 128'(ram_en), 128'd0);
    check("rst_ram_addr", 128'(ram_addr), 128'd0);
    #6 rst = 1'b1;
    step(2);

    // Plain fill of line 0x1230.
    e0 = cyc + 1;
    push_fill(32'h0000_1234, e0, 0);
    req = 1'b1; req_addr = 32'h0000_1234;
    step(1);
    req = 1'b0;
    check("busy_fill", 128'(busy), 128'd1);
    step(20);
    check("busy_after", 128'(busy), 128'd0);
    check("line_hold", line, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
    drained("plain");

    // Same fill with three stalled issue cycles after byte 5.
    e0 = cyc + 1;
    push_fill(32'h0000_1234, e0, 3);
    req = 1'b1; req_addr = 32'h0000_1234;
    step(1);
    req = 1'b0;
    step(5);
    mem_stall = 1'b1;
    step(3);
    mem_stall = 1'b0;
    step(22);
    drained("stall");

    // Flush after byte 8 captured: only bytes 0..10 reach the bus, no done.
    for (int k = 0; k < 11; k++) addr_q.push_back(32'h0000_1230 + 32'(k));
    req = 1'b1; req_addr = 32'h0000_1230;
    step(1);
    req = 1'b0;
    step(10);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("flush_busy", 128'(busy), 128'd0);
    check("flush_ram_en", 128'(ram_en), 128'd0);
    step(5);
    drained("flush");

    // Flush and request together: request dropped.
    flush = 1'b1; req = 1'b1; req_addr = 32'h0000_5000;
    step(1);
    flush = 1'b0; req = 1'b0;
    check("flush_req_busy", 128'(busy), 128'd0);
    step(3);

    // Fill of 0x2000 after the flush.
    e0 = cyc + 1;
    push_fill(32'h0000_2000, e0, 0);
    req = 1'b1; req_addr = 32'h0000_2000;
    step(1);
    req = 1'b0;
    step(20);
    drained("after_flush");

    // Request held through the two edges after DONE.
    e0 = cyc + 1;
    push_fill(32'h0000_0040, e0, 0);
`ifndef ICACHE_REFILL_DEDUP_EN
    push_fill(32'h0000_0040, e0 + 18, 0);
`endif
    req = 1'b1; req_addr = 32'h0000_0040;
    step(20);
    req = 1'b0;
`ifdef ICACHE_REFILL_DEDUP_EN
    check("dedup_busy", 128'(busy), 128'd0);
`else
    check("refill_busy", 128'(busy), 128'd1);
`endif
    step(40);
    drained("held_req");

    // Asynchronous reset in the middle of a fill.
    push_fill(32'h0000_1230, cyc + 1, 0);
    req = 1'b1; req_addr = 32'h0000_1230;
    step(1);
    req = 1'b0;
    step(8);
    #2 rst = 1'b0;
    #1;
    check("arst_done", 128'(done), 128'd0);
    check("arst_line", line, 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_ram_en", 128'(ram_en), 128'd0);
    check("arst_ram_addr", 128'(ram_addr), 128'd0);
    addr_q.delete();
    line_q.delete();
    #3 rst = 1'b1;
    step(2);

    e0 = cyc + 1;
    push_fill(32'h0000_3458, e0, 0);
    req = 1'b1; req_addr = 32'h0000_3458;
    step(1);
    req = 1'b0;
    step(20);
    drained("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
